// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the loader FSM state encoding.
package cnn_pkg;

    localparam int DATA_W         = 64;
    localparam int PIX_W          = 8;
    localparam int PIX_PER_WORD   = DATA_W / PIX_W;
    localparam int BRAM32K_ADDR_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

endpackage

// File: rtl/pix_packer.sv
// Pixel packer: drops each accepted pixel into the next byte lane of a word.
// word is the packed word including the pixel presented this cycle, so the
// caller can register it on the same edge that accepts the filling pixel.
module pix_packer #(
    parameter int DATA_W = 64,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              pix_en,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              word_full,
    output logic [DATA_W-1:0] word
);
    import cnn_pkg::*;

    localparam int LANES  = DATA_W / PIX_W;
    localparam int LANE_W = $clog2(LANES);

    logic [LANE_W-1:0] lane_q;
    logic [DATA_W-1:0] pack_q;

    // Merge the incoming pixel into its lane and flag the lane that completes a word.
    always_comb begin
        word      = pack_q;
        word_full = 1'b0;
        if (pix_en) begin
            word[lane_q*PIX_W +: PIX_W] = pix_data;
            word_full = (lane_q == LANE_W'(LANES - 1));
        end
    end

    // Lane counter and pack register; a completed word starts the next one from zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            lane_q <= '0;
            pack_q <= '0;
        end else if (pix_en) begin
            lane_q <= lane_q + 1'b1;
            pack_q <= word_full ? '0 : word;
        end
    end

endmodule

// File: rtl/ifmap_loader.sv
// Input-feature-map loader: packs a pixel stream into BRAM words for one frame,
// then pulses done so the controller can launch layer-1 convolution.
//
// state  | meaning
// IDLE   | waiting for start, pix_ready low
// LOAD   | accepting pixels, each completed word written the next cycle
// FLUSH  | partial last word on the BRAM port (unfilled lanes zero)
// DONE   | frame finished, return to IDLE
module ifmap_loader #(
    parameter int DATA_W    = cnn_pkg::DATA_W,
    parameter int PIX_W     = cnn_pkg::PIX_W,
    parameter int ADDR_W    = cnn_pkg::BRAM32K_ADDR_W,
    parameter int NUM_PIX   = 784,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic              we_bram,
    output logic [ADDR_W-1:0] addr_bram,
    output logic [DATA_W-1:0] din_bram,
    output logic              busy,
    output logic              done
);
    import cnn_pkg::*;

    localparam int PIX_CNT_W = $clog2(NUM_PIX + 1);

    load_state_t          state_q, state_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q;
    logic [ADDR_W-1:0]    word_cnt_q;
    logic                 we_q, busy_q, done_q, final_wr_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    din_q;

    logic                 accept, last_pix, start_acc, word_full, write_now;
    logic [DATA_W-1:0]    packed_word;

    assign pix_ready = (state_q == ST_LOAD);
    assign accept    = pix_valid && pix_ready;
    assign last_pix  = (pix_cnt_q == PIX_CNT_W'(NUM_PIX - 1));
    assign start_acc = (state_q == ST_IDLE) && start;
    assign write_now = accept && (word_full || last_pix);

    pix_packer #(
        .DATA_W (DATA_W),
        .PIX_W  (PIX_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_acc || (accept && last_pix)),
        .pix_en    (accept),
        .pix_data  (pix_data),
        .word_full (word_full),
        .word      (packed_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a frame ending on a lane boundary needs no flush step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (accept && last_pix) state_d = word_full ? ST_DONE : ST_FLUSH;
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counters, BRAM port registers and the busy/done handshake.
    // done follows the final write by one cycle regardless of whether it was a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q  <= '0;
            word_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            final_wr_q <= 1'b0;
        end else begin
            we_q       <= write_now;
            final_wr_q <= accept && last_pix;
            done_q     <= final_wr_q;
            if (write_now) begin
                addr_q <= ADDR_W'(BASE_ADDR) + word_cnt_q;
                din_q  <= packed_word;
            end
            if (final_wr_q) begin
                busy_q <= 1'b0;
            end else if (start_acc) begin
                busy_q <= 1'b1;
            end
            if (start_acc) begin
                pix_cnt_q  <= '0;
                word_cnt_q <= '0;
            end else if (accept) begin
                pix_cnt_q <= pix_cnt_q + 1'b1;
                if (word_full && !last_pix) begin
                    word_cnt_q <= word_cnt_q + 1'b1;
                end
            end
        end
    end

    assign we_bram   = we_q;
    assign addr_bram = addr_q;
    assign din_bram  = din_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ifmap_loader.sv
// Bench for ifmap_loader: four instances cover the frame-size / base-address variants;
// one is selected at a time and checked every cycle against a frame-level model.
module tb_ifmap_loader;

    logic        clk = 1'b0;
    logic        rst, start, pix_valid;
    logic [7:0]  pix_data;
    int          sel;

    logic [3:0]  ready_v, we_v, busy_v, done_v;
    logic [11:0] addr_v [4];
    logic [63:0] din_v  [4];

    always #5 clk = ~clk;

    ifmap_loader #(.NUM_PIX(16), .BASE_ADDR(0)) u_a (
        .clk(clk), .rst(rst), .start(start && (sel == 0)), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(ready_v[0]), .we_bram(we_v[0]), .addr_bram(addr_v[0]), .din_bram(din_v[0]),
        .busy(busy_v[0]), .done(done_v[0]));
    ifmap_loader #(.NUM_PIX(20), .BASE_ADDR(0)) u_b (
        .clk(clk), .rst(rst), .start(start && (sel == 1)), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(ready_v[1]), .we_bram(we_v[1]), .addr_bram(addr_v[1]), .din_bram(din_v[1]),
        .busy(busy_v[1]), .done(done_v[1]));
    ifmap_loader #(.NUM_PIX(16), .BASE_ADDR(12'h100)) u_c (
        .clk(clk), .rst(rst), .start(start && (sel == 2)), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(ready_v[2]), .we_bram(we_v[2]), .addr_bram(addr_v[2]), .din_bram(din_v[2]),
        .busy(busy_v[2]), .done(done_v[2]));
    ifmap_loader u_d (
        .clk(clk), .rst(rst), .start(start && (sel == 3)), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(ready_v[3]), .we_bram(we_v[3]), .addr_bram(addr_v[3]), .din_bram(din_v[3]),
        .busy(busy_v[3]), .done(done_v[3]));

    logic        ready_sel, we_sel, busy_sel, done_sel;
    logic [11:0] addr_sel;
    logic [63:0] din_sel;
    assign ready_sel = ready_v[sel];
    assign we_sel    = we_v[sel];
    assign busy_sel  = busy_v[sel];
    assign done_sel  = done_v[sel];
    assign addr_sel  = addr_v[sel];
    assign din_sel   = din_v[sel];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int frame_pix(input int s);
        return (s == 1) ? 20 : (s == 3) ? 784 : 16;
    endfunction

    function automatic int frame_base(input int s);
        return (s == 2) ? 'h100 : 0;
    endfunction

    // ---------------- frame-level model ----------------
    bit          m_open, m_loading, m_done_pend;
    int          m_cnt;
    logic [63:0] m_word;
    logic [63:0] m_mem [128];
    bit          exp_ready, exp_we, exp_busy, exp_done;
    logic [11:0] exp_addr;
    logic [63:0] exp_din;

    // DUT write log and event bookkeeping
    logic [11:0] log_addr [256];
    logic [63:0] log_din  [256];
    int          log_n = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          last_we_cyc = 0;
    int          last_done_cyc = 0;
    bit          busy_at_done = 1'b1;

    initial begin
        m_open = 0; m_loading = 0; m_done_pend = 0; m_cnt = 0; m_word = '0;
        exp_ready = 0; exp_we = 0; exp_busy = 0; exp_done = 0; exp_addr = '0; exp_din = '0;
    end

    always begin
        bit          s_rst, s_start, s_valid, acc, close;
        logic [7:0]  s_data;
        int          widx;
        @(posedge clk);
        cyc++;
        s_rst = rst; s_start = start; s_valid = pix_valid; s_data = pix_data;
        acc   = s_valid && exp_ready;
        close = 0;
        exp_we   = 0;
        exp_done = 0;
        if (s_rst) begin
            m_open = 0; m_loading = 0; m_done_pend = 0;
            exp_busy = 0; exp_ready = 0;
        end else begin
            if (m_done_pend) begin
                exp_done = 1; exp_busy = 0; m_done_pend = 0; close = 1;
            end
            if (s_start && !m_open) begin
                m_open = 1; m_loading = 1; m_cnt = 0; m_word = '0; exp_busy = 1;
            end
            if (acc) begin
                m_word[(m_cnt % 8) * 8 +: 8] = s_data;
                m_cnt++;
                if ((m_cnt % 8 == 0) || (m_cnt == frame_pix(sel))) begin
                    widx     = (m_cnt - 1) / 8;
                    exp_we   = 1;
                    exp_addr = 12'(frame_base(sel) + widx);
                    exp_din  = m_word;
                    m_mem[widx] = m_word;
                    m_word   = '0;
                end
                if (m_cnt == frame_pix(sel)) begin
                    m_loading = 0; m_done_pend = 1;
                end
            end
            if (close) m_open = 0;
            exp_ready = m_loading;
        end
        #1;
        check("pix_ready", ready_sel, exp_ready);
        check("we_bram", we_sel, exp_we);
        if (exp_we) begin
            check("addr_bram", addr_sel, exp_addr);
            check("din_bram", din_sel, exp_din);
        end
        check("busy", busy_sel, exp_busy);
        check("done", done_sel, exp_done);
        if (we_sel === 1'b1 && log_n < 256) begin
            log_addr[log_n] = addr_sel;
            log_din[log_n]  = din_sel;
            log_n++;
            last_we_cyc = cyc;
        end
        if (done_sel === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            busy_at_done  = busy_sel;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit gaps, input bit rnd, input int start_at);
        int k   = 0;
        int c   = 0;
        bit ph  = 1'b1;
        while (k < n && c < 4000) begin
            pix_valid = gaps ? ph : 1'b1;
            ph        = !ph;
            pix_data  = rnd ? 8'($urandom_range(0, 255)) : 8'(k + 1);
            start     = (k == start_at);
            if (pix_valid && ready_sel) k++;
            @(negedge clk);
            c++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        check("frame_sent", k, n);
    endtask

    task automatic wait_done(input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (done_sel) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int mark;
        int dmark;
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = '0; sel = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready_sel, 0);
        check("rst_we", we_sel, 0);
        check("rst_busy", busy_sel, 0);
        check("rst_done", done_sel, 0);

        // 1: reset held mid-LOAD
        mark = log_n;
        do_start();
        send_frame(5, 0, 0, -1);
        rst = 1'b1; pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; pix_valid = 1'b0;
        @(negedge clk);
        check("midrst_ready", ready_sel, 0);
        check("midrst_busy", busy_sel, 0);
        check("midrst_we", we_sel, 0);
        check("midrst_addr", addr_sel, 0);
        check("midrst_din", din_sel, 0);
        repeat (6) @(negedge clk);
        check("midrst_writes", log_n - mark, 0);

        // 2: 16-pixel frame, back-to-back
        mark = log_n;
        do_start();
        send_frame(16, 0, 0, -1);
        wait_done(10);
        check("t2_writes", log_n - mark, 2);
        check("t2_addr0", log_addr[mark], 12'h000);
        check("t2_din0", log_din[mark], 64'h0807060504030201);
        check("t2_addr1", log_addr[mark+1], 12'h001);
        check("t2_din1", log_din[mark+1], 64'h100F0E0D0C0B0A09);
        check("t2_done_lag", last_done_cyc - last_we_cyc, 1);
        check("t2_busy_at_done", busy_at_done, 0);

        // 3: 20-pixel frame ending in a partial word
        sel = 1;
        mark = log_n;
        @(negedge clk);
        do_start();
        send_frame(20, 0, 0, -1);
        wait_done(10);
        check("t3_writes", log_n - mark, 3);
        check("t3_din1", log_din[mark+1], 64'h100F0E0D0C0B0A09);
        check("t3_addr2", log_addr[mark+2], 12'h002);
        check("t3_din2", log_din[mark+2], 64'h0000000014131211);
        check("t3_done_lag", last_done_cyc - last_we_cyc, 1);

        // 4: gapped pixel stream, base address 0x100
        sel = 2;
        mark = log_n;
        @(negedge clk);
        do_start();
        send_frame(16, 1, 0, -1);
        wait_done(10);
        check("t4_writes", log_n - mark, 2);
        check("t4_addr0", log_addr[mark], 12'h100);
        check("t4_din0", log_din[mark], 64'h0807060504030201);
        check("t4_addr1", log_addr[mark+1], 12'h101);
        check("t4_din1", log_din[mark+1], 64'h100F0E0D0C0B0A09);

        // 5: pix_valid in IDLE, start re-pulsed during LOAD
        sel = 0;
        mark = log_n;
        @(negedge clk);
        pix_valid = 1'b1; pix_data = 8'hAA;
        for (int i = 0; i < 4; i++) begin
            check("t5_idle_ready", ready_sel, 0);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        check("t5_idle_writes", log_n - mark, 0);
        do_start();
        send_frame(16, 0, 0, 6);
        wait_done(10);
        check("t5_writes", log_n - mark, 2);
        check("t5_din0", log_din[mark], 64'h0807060504030201);
        check("t5_addr1", log_addr[mark+1], 12'h001);
        check("t5_din1", log_din[mark+1], 64'h100F0E0D0C0B0A09);

        // 6: default 784-pixel frame, random pixels
        sel = 3;
        mark = log_n;
        dmark = done_cnt;
        @(negedge clk);
        do_start();
        send_frame(784, 0, 1, -1);
        wait_done(10);
        repeat (5) @(negedge clk);
        check("t6_writes", log_n - mark, 98);
        check("t6_done_count", done_cnt - dmark, 1);
        for (int i = 0; i < 98; i++) begin
            check("t6_addr", log_addr[mark+i], 12'(i));
            check("t6_din", log_din[mark+i], m_mem[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
